uart_rx_bit_timer: RTL and testbench

//  Parametrised edge/bit timing engine for the UART receiver; successor to the fixed 8N1/8E1 counter.

---
 rtl/uart_rx_pkg.sv | 16 +
 rtl/uart_rx_frame_cfg.sv | 56 +++++
 rtl/uart_rx_bit_timer.sv | 84 ++++++++
 tb/tb_uart_rx_bit_timer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared constants and frame-length helper for the UART receiver timing path.
package uart_rx_pkg;

    localparam int unsigned MIN_PRESCALE = 4;
    localparam int unsigned MIN_DATA     = 5;
    localparam int unsigned RST_PRESCALE = 8;
    localparam int unsigned RST_DATA     = 8;

    // Start + data + optional parity + one or two stop bits; 5 bits cover any 4-bit data length.
    function automatic logic [4:0] frame_len(input logic [3:0] data_len,
                                             input logic       par_en,
                                             input logic       stop2);
        return 5'd1 + {1'b0, data_len} + {4'd0, par_en} + (stop2 ? 5'd2 : 5'd1);
    endfunction

endpackage

// File: rtl/uart_rx_frame_cfg.sv
// Frame configuration latch: clamps runtime config at frame start and holds it for the frame.
module uart_rx_frame_cfg
    import uart_rx_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 6,
    parameter int unsigned MAX_DATA   = 9,
    parameter int unsigned BIT_CNT_W  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_capture,
    input  logic [PRESCALE_W-1:0] i_cfg_prescale,
    input  logic [3:0]            i_cfg_data_len,
    input  logic                  i_cfg_par_en,
    input  logic                  i_cfg_stop2,
    output logic [PRESCALE_W-1:0] o_prescale,
    output logic [BIT_CNT_W-1:0]  o_last_bit,
    output logic                  o_cfg_err
);

    logic                  w_pre_low;
    logic                  w_len_bad;
    logic [PRESCALE_W-1:0] w_prescale;
    logic [3:0]            w_data_len;
    logic [4:0]            w_frame_len;

    logic [PRESCALE_W-1:0] r_prescale;
    logic [BIT_CNT_W-1:0]  r_last_bit;
    logic                  r_cfg_err;

    always_comb begin
        w_pre_low   = i_cfg_prescale < PRESCALE_W'(MIN_PRESCALE);
        w_len_bad   = (i_cfg_data_len < 4'(MIN_DATA)) || (i_cfg_data_len > 4'(MAX_DATA));
        w_prescale  = w_pre_low ? PRESCALE_W'(MIN_PRESCALE) : i_cfg_prescale;
        w_data_len  = w_len_bad ? 4'(MAX_DATA) : i_cfg_data_len;
        w_frame_len = frame_len(w_data_len, i_cfg_par_en, i_cfg_stop2);
    end

    // Last bit index is stored rather than the length so the counter compares directly.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prescale <= PRESCALE_W'(RST_PRESCALE);
            r_last_bit <= BIT_CNT_W'(frame_len(4'(RST_DATA), 1'b0, 1'b0) - 5'd1);
            r_cfg_err  <= 1'b0;
        end else if (i_capture) begin
            r_prescale <= w_prescale;
            r_last_bit <= BIT_CNT_W'(w_frame_len - 5'd1);
            r_cfg_err  <= w_pre_low | w_len_bad;
        end
    end

    assign o_prescale = r_prescale;
    assign o_last_bit = r_last_bit;
    assign o_cfg_err  = r_cfg_err;

endmodule

// File: rtl/uart_rx_bit_timer.sv
// UART RX edge/bit timing engine: oversampling edge counter, frame bit counter and
// mid-bit sample strobes driven from the frame configuration latched at frame start.
module uart_rx_bit_timer
    import uart_rx_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 6,
    parameter int unsigned MAX_DATA   = 9,
    parameter int unsigned BIT_CNT_W  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cnt_en,
    input  logic [PRESCALE_W-1:0] i_cfg_prescale,
    input  logic [3:0]            i_cfg_data_len,
    input  logic                  i_cfg_par_en,
    input  logic                  i_cfg_stop2,
    output logic [PRESCALE_W-1:0] o_edge_count,
    output logic [BIT_CNT_W-1:0]  o_bit_count,
    output logic                  o_done_edge,
    output logic [2:0]            o_sample_strb,
    output logic                  o_frame_done,
    output logic                  o_cfg_err
);

    logic [PRESCALE_W-1:0] r_edge_count;
    logic [BIT_CNT_W-1:0]  r_bit_count;

    logic                  w_capture;
    logic [PRESCALE_W-1:0] w_prescale;
    logic [PRESCALE_W-1:0] w_mid;
    logic [BIT_CNT_W-1:0]  w_last_bit;
    logic                  w_done_edge;
    logic                  w_frame_done;

    // Capture also fires on the first edge of a back-to-back frame after the wrap.
    assign w_capture = i_cnt_en && (r_edge_count == '0) && (r_bit_count == '0);

    uart_rx_frame_cfg #(
        .PRESCALE_W (PRESCALE_W),
        .MAX_DATA   (MAX_DATA),
        .BIT_CNT_W  (BIT_CNT_W)
    ) u_frame_cfg (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_capture      (w_capture),
        .i_cfg_prescale (i_cfg_prescale),
        .i_cfg_data_len (i_cfg_data_len),
        .i_cfg_par_en   (i_cfg_par_en),
        .i_cfg_stop2    (i_cfg_stop2),
        .o_prescale     (w_prescale),
        .o_last_bit     (w_last_bit),
        .o_cfg_err      (o_cfg_err)
    );

    always_comb begin
        w_mid        = w_prescale >> 1;
        w_done_edge  = i_cnt_en && (r_edge_count == w_prescale - 1'b1);
        w_frame_done = w_done_edge && (r_bit_count == w_last_bit);
        o_sample_strb = '0;
        if (i_cnt_en) begin
            o_sample_strb[0] = r_edge_count == w_mid - 1'b1;
            o_sample_strb[1] = r_edge_count == w_mid;
            o_sample_strb[2] = r_edge_count == w_mid + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_cnt_en) begin
            r_edge_count <= '0;
            r_bit_count  <= '0;
        end else if (w_done_edge) begin
            r_edge_count <= '0;
            r_bit_count  <= w_frame_done ? '0 : r_bit_count + 1'b1;
        end else begin
            r_edge_count <= r_edge_count + 1'b1;
        end
    end

    assign o_edge_count = r_edge_count;
    assign o_bit_count  = r_bit_count;
    assign o_done_edge  = w_done_edge;
    assign o_frame_done = w_frame_done;

endmodule

// File: tb/tb_uart_rx_bit_timer.sv
// Self-checking bench for uart_rx_bit_timer: directed frame scenarios plus randomized
// traffic, compared cycle by cycle against a frame-offset arithmetic reference model.
module tb_uart_rx_bit_timer;

    localparam int PW = 6;
    localparam int MD = 9;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cnt_en;
    logic [PW-1:0] cfg_prescale;
    logic [3:0]    cfg_data_len;
    logic          cfg_par_en;
    logic          cfg_stop2;
    logic [PW-1:0] edge_count;
    logic [BW-1:0] bit_count;
    logic          done_edge;
    logic [2:0]    sample_strb;
    logic          frame_done;
    logic          cfg_err;

    uart_rx_bit_timer #(
        .PRESCALE_W (PW),
        .MAX_DATA   (MD),
        .BIT_CNT_W  (BW)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_cnt_en       (cnt_en),
        .i_cfg_prescale (cfg_prescale),
        .i_cfg_data_len (cfg_data_len),
        .i_cfg_par_en   (cfg_par_en),
        .i_cfg_stop2    (cfg_stop2),
        .o_edge_count   (edge_count),
        .o_bit_count    (bit_count),
        .o_done_edge    (done_edge),
        .o_sample_strb  (sample_strb),
        .o_frame_done   (frame_done),
        .o_cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: m_t = clocks since the current frame started; config latched at frame start.
    int m_t;
    int m_p;
    int m_l;
    int m_err;
    int cyc;
    int done_cnt;
    int fd_q[$];

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_cfg(input int p, input int d, input bit par, input bit s2);
        cfg_prescale = PW'(p);
        cfg_data_len = 4'(d);
        cfg_par_en   = par;
        cfg_stop2    = s2;
    endtask

    task automatic model_reset();
        m_t   = 0;
        m_p   = 8;
        m_l   = 10;
        m_err = 0;
    endtask

    // Check outputs for the current cycle, advance the model, then step one clock.
    task automatic tick();
        int e;
        int b;
        int mid;
        int dn;
        int strb;
        int p;
        int d;
        #2;
        e    = m_t % m_p;
        b    = m_t / m_p;
        mid  = m_p / 2;
        dn   = (cnt_en && e == m_p - 1) ? 1 : 0;
        strb = 0;
        if (cnt_en) begin
            if (e == mid - 1) strb += 1;
            if (e == mid)     strb += 2;
            if (e == mid + 1) strb += 4;
        end
        check_eq("edge_count", int'(edge_count), e);
        check_eq("bit_count", int'(bit_count), b);
        check_eq("done_edge", int'(done_edge), dn);
        check_eq("sample_strb", int'(sample_strb), strb);
        check_eq("frame_done", int'(frame_done), (dn == 1 && b == m_l - 1) ? 1 : 0);
        check_eq("cfg_err", int'(cfg_err), m_err);
        if (done_edge) done_cnt++;
        if (frame_done) fd_q.push_back(cyc);
        cyc++;
        if (rst) begin
            model_reset();
        end else if (!cnt_en) begin
            m_t = 0;
        end else begin
            if (m_t == 0) begin
                p     = (int'(cfg_prescale) < 4) ? 4 : int'(cfg_prescale);
                d     = (int'(cfg_data_len) < 5 || int'(cfg_data_len) > MD) ? MD
                                                                          : int'(cfg_data_len);
                m_err = (int'(cfg_prescale) < 4 || d != int'(cfg_data_len)) ? 1 : 0;
                m_p   = p;
                m_l   = 1 + d + int'(cfg_par_en) + (cfg_stop2 ? 2 : 1);
            end
            m_t++;
            if (m_t == m_p * m_l) m_t = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_scenario();
        cyc      = 0;
        done_cnt = 0;
        fd_q.delete();
    endtask

    initial begin
        rst    = 1'b1;
        cnt_en = 1'b0;
        set_cfg(8, 8, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        model_reset();
        start_scenario();
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // 8N1 at prescale 8 for 80 clocks: one frame, done every 8 clocks.
        set_cfg(8, 8, 1'b0, 1'b0);
        cnt_en = 1'b1;
        start_scenario();
        repeat (80) tick();
        check_eq("8n1_done_cnt", done_cnt, 10);
        check_eq("8n1_fd_cnt", fd_q.size(), 1);
        if (fd_q.size() > 0) check_eq("8n1_fd_clk", fd_q[0], 79);
        cnt_en = 1'b0;
        tick();

        // 7E2 at prescale 16: 11 bits, frame done after 176 clocks, then wraps.
        set_cfg(16, 7, 1'b1, 1'b1);
        cnt_en = 1'b1;
        start_scenario();
        repeat (176) tick();
        check_eq("7e2_fd_cnt", fd_q.size(), 1);
        if (fd_q.size() > 0) check_eq("7e2_fd_clk", fd_q[0], 175);
        check_eq("7e2_wrap_bit", int'(bit_count), 0);
        cnt_en = 1'b0;
        tick();

        // Back-to-back: 8E1 frame with config flipped to 8N1 mid-frame, then an 8N1 frame.
        set_cfg(8, 8, 1'b1, 1'b0);
        cnt_en = 1'b1;
        start_scenario();
        for (int i = 0; i < 168; i++) begin
            if (i == 30) set_cfg(8, 8, 1'b0, 1'b0);
            tick();
        end
        check_eq("b2b_fd_cnt", fd_q.size(), 2);
        if (fd_q.size() == 2) begin
            check_eq("b2b_fd1_clk", fd_q[0], 87);
            check_eq("b2b_fd2_clk", fd_q[1], 167);
        end
        cnt_en = 1'b0;
        tick();

        // Abort at bit 4 edge 3.
        set_cfg(8, 8, 1'b0, 1'b0);
        cnt_en = 1'b1;
        start_scenario();
        repeat (35) tick();
        check_eq("abort_pre_bit", int'(bit_count), 4);
        check_eq("abort_pre_edge", int'(edge_count), 3);
        cnt_en = 1'b0;
        tick();
        check_eq("abort_bit", int'(bit_count), 0);
        check_eq("abort_edge", int'(edge_count), 0);
        check_eq("abort_fd_cnt", fd_q.size(), 0);

        // Clamp: prescale 2 -> 4, data 12 -> MAX_DATA; 9N1 frame of 11 bits x 4 edges.
        set_cfg(2, 12, 1'b0, 1'b0);
        cnt_en = 1'b1;
        start_scenario();
        tick();
        check_eq("clamp_err", int'(cfg_err), 1);
        repeat (43) tick();
        check_eq("clamp_fd_cnt", fd_q.size(), 1);
        if (fd_q.size() > 0) check_eq("clamp_fd_clk", fd_q[0], 43);

        // Reset mid-frame while enabled and with a clamped config latched.
        set_cfg(3, 6, 1'b1, 1'b1);
        repeat (20) tick();
        rst = 1'b1;
        tick();
        check_eq("rst_err", int'(cfg_err), 0);
        check_eq("rst_edge", int'(edge_count), 0);
        check_eq("rst_bit", int'(bit_count), 0);
        rst = 1'b0;
        cnt_en = 1'b0;
        tick();

        // Randomized traffic: config churn, enable drops and occasional reset.
        cnt_en = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                if ($urandom_range(0, 3) == 0)
                    cfg_prescale = PW'($urandom_range(0, 63));
                else
                    cfg_prescale = PW'($urandom_range(0, 12));
                cfg_data_len = 4'($urandom_range(0, 15));
                cfg_par_en   = 1'($urandom_range(0, 1));
                cfg_stop2    = 1'($urandom_range(0, 1));
            end
            if (cnt_en && $urandom_range(0, 299) == 0) cnt_en = 1'b0;
            else if (!cnt_en && $urandom_range(0, 4) == 0) cnt_en = 1'b1;
            rst = ($urandom_range(0, 799) == 0);
            tick();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
